// File: rtl/csi_rx_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_depacketizer
// Description : CSI-2 byte-stream depacketizer. It decodes FS/FE short packets
//               and RAW14 long packets into a 14-bit pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module csi_rx_depacketizer #(
  parameter logic [1:0] VIRTUAL_CHANNEL   = 2'h0,
  parameter logic [7:0] EXPECTED_ECC      = 8'hCC,
  parameter int         IMAGE_PIXEL_WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_active,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         pix_valid,
  output logic [IMAGE_PIXEL_WIDTH-1:0] pix_data,
  output logic                         pix_sol,
  output logic                         pix_eol,
  output logic                         frame_start,
  output logic                         frame_end,
  output logic [15:0]                  frame_num,
  output logic [15:0]                  line_num,
  output logic                         err_ecc,
  output logic                         err_dt,
  output logic                         err_wc,
  output logic                         err_trunc
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HDR        = 3'd1,
    S_PAYLOAD    = 3'd2,
    S_FOOTER     = 3'd3,
    S_DROP       = 3'd4,
    S_DROP_BURST = 3'd5
  } state_t;

  localparam logic [5:0] c_dt_fs       = 6'h00;
  localparam logic [5:0] c_dt_fe       = 6'h01;
  localparam logic [5:0] c_dt_raw14    = 6'h2D;
  localparam logic [5:0] c_dt_long_min = 6'h10;

  state_t      r_state;
  logic [1:0]  r_hdr_cnt;
  logic [7:0]  r_di;
  logic [7:0]  r_wc_lo;
  logic [7:0]  r_wc_hi;
  logic [16:0] r_remain;
  logic [2:0]  r_gidx;
  logic [7:0]  r_grp [0:5];
  logic        r_first;
  logic [13:0] r_pix_q [0:2];
  logic [1:0]  r_drain_cnt;
  logic        r_eol_q;

  logic [15:0] w_wc;
  logic        w_wc_ok;
  logic        w_hdr_done;
  logic        w_last_byte;
  logic        w_grp_done;
  state_t      w_dec_state;
  logic        w_dec_fs, w_dec_fe, w_dec_err_ecc, w_dec_err_dt, w_dec_err_wc;
  state_t      w_state_nxt;
  state_t      w_state_fin;
  logic [1:0]  w_hdr_cnt_nxt;
  logic        w_trunc;
  logic [13:0] w_p1, w_p2, w_p3, w_p4;

  assign w_wc        = {r_wc_hi, r_wc_lo};
  assign w_wc_ok     = (w_wc != 16'd0) && ((w_wc % 16'd7) == 16'd0);
  assign w_hdr_done  = (r_state == S_HDR) && rx_valid && (r_hdr_cnt == 2'd3);
  assign w_last_byte = (r_remain == 17'd1);
  assign w_grp_done  = (r_state == S_PAYLOAD) && rx_valid && (r_gidx == 3'd6);

  // Group byte 6 is the live rx_data byte, so pixels are ready on its accept edge
  assign w_p1 = {r_grp[0], r_grp[4][5:0]};
  assign w_p2 = {r_grp[1], r_grp[5][3:0], r_grp[4][7:6]};
  assign w_p3 = {r_grp[2], rx_data[1:0], r_grp[5][7:4]};
  assign w_p4 = {r_grp[3], rx_data[7:2]};

  always_comb begin
    w_dec_state   = S_HDR;
    w_dec_fs      = 1'b0;
    w_dec_fe      = 1'b0;
    w_dec_err_ecc = 1'b0;
    w_dec_err_dt  = 1'b0;
    w_dec_err_wc  = 1'b0;
    if (rx_data != EXPECTED_ECC) begin
      w_dec_err_ecc = 1'b1;
      w_dec_state   = S_DROP_BURST;
    end else if (r_di[7:6] != VIRTUAL_CHANNEL) begin
      if (r_di[5:0] >= c_dt_long_min) w_dec_state = S_DROP;
    end else begin
      case (r_di[5:0])
        c_dt_fs: w_dec_fs = 1'b1;
        c_dt_fe: w_dec_fe = 1'b1;
        c_dt_raw14: begin
          if (w_wc_ok) begin
            w_dec_state = S_PAYLOAD;
          end else begin
            w_dec_err_wc = 1'b1;
            w_dec_state  = S_DROP;
          end
        end
        default: begin
          w_dec_err_dt = 1'b1;
          if (r_di[5:0] >= c_dt_long_min) w_dec_state = S_DROP;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_cnt_nxt = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_active) begin
          w_state_nxt   = S_HDR;
          w_hdr_cnt_nxt = 2'd1;
        end
      end
      S_HDR: begin
        w_hdr_cnt_nxt = rx_valid ? r_hdr_cnt + 2'd1 : r_hdr_cnt;
        if (w_hdr_done) w_state_nxt = w_dec_state;
      end
      S_PAYLOAD: if (rx_valid && w_last_byte) w_state_nxt = S_FOOTER;
      S_FOOTER, S_DROP: if (rx_valid && w_last_byte) w_state_nxt = S_HDR;
      default: ;
    endcase
    // A byte arriving as rx_active drops is still consumed before judging truncation
    w_trunc = !rx_active &&
              ((w_state_nxt inside {S_PAYLOAD, S_FOOTER, S_DROP}) ||
               ((w_state_nxt == S_HDR) && (w_hdr_cnt_nxt != 2'd0)));
    w_state_fin = rx_active ? w_state_nxt : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_di        <= 8'd0;
      r_wc_lo     <= 8'd0;
      r_wc_hi     <= 8'd0;
      r_remain    <= 17'd0;
      r_gidx      <= 3'd0;
      r_first     <= 1'b0;
      r_drain_cnt <= 2'd0;
      r_eol_q     <= 1'b0;
      for (int i = 0; i < 6; i++) r_grp[i] <= 8'd0;
      for (int i = 0; i < 3; i++) r_pix_q[i] <= 14'd0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_sol     <= 1'b0;
      pix_eol     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_num   <= 16'd0;
      line_num    <= 16'd0;
      err_ecc     <= 1'b0;
      err_dt      <= 1'b0;
      err_wc      <= 1'b0;
      err_trunc   <= 1'b0;
    end else begin
      r_state     <= w_state_fin;
      r_hdr_cnt   <= rx_active ? w_hdr_cnt_nxt : 2'd0;
      frame_start <= w_hdr_done && w_dec_fs;
      frame_end   <= w_hdr_done && w_dec_fe;
      err_ecc     <= w_hdr_done && w_dec_err_ecc;
      err_dt      <= w_hdr_done && w_dec_err_dt;
      err_wc      <= w_hdr_done && w_dec_err_wc;
      err_trunc   <= w_trunc;
      pix_sol     <= 1'b0;
      pix_eol     <= 1'b0;

      if (rx_valid && (((r_state == S_IDLE) && rx_active) ||
                       ((r_state == S_HDR) && (r_hdr_cnt != 2'd3)))) begin
        case (r_hdr_cnt)
          2'd0:    r_di    <= rx_data;
          2'd1:    r_wc_lo <= rx_data;
          2'd2:    r_wc_hi <= rx_data;
          default: ;
        endcase
      end

      if (w_hdr_done) begin
        r_remain <= (w_dec_state == S_DROP) ? {1'b0, w_wc} + 17'd2 : {1'b0, w_wc};
        r_gidx   <= 3'd0;
        r_first  <= 1'b1;
        if (w_dec_fs) frame_num <= w_wc;
      end

      if (rx_valid && (r_state inside {S_PAYLOAD, S_FOOTER, S_DROP}))
        r_remain <= ((r_state == S_PAYLOAD) && w_last_byte) ? 17'd2 : r_remain - 17'd1;

      if ((r_state == S_PAYLOAD) && rx_valid) begin
        if (r_gidx == 3'd6) begin
          r_gidx <= 3'd0;
        end else begin
          r_grp[r_gidx] <= rx_data;
          r_gidx        <= r_gidx + 3'd1;
        end
      end

      if (w_grp_done) begin
        pix_valid   <= 1'b1;
        pix_data    <= w_p1;
        pix_sol     <= r_first;
        r_first     <= 1'b0;
        r_pix_q[0]  <= w_p2;
        r_pix_q[1]  <= w_p3;
        r_pix_q[2]  <= w_p4;
        r_drain_cnt <= 2'd3;
        r_eol_q     <= w_last_byte && !w_trunc;
      end else if (r_drain_cnt != 2'd0) begin
        pix_valid   <= 1'b1;
        pix_data    <= r_pix_q[0];
        r_pix_q[0]  <= r_pix_q[1];
        r_pix_q[1]  <= r_pix_q[2];
        r_drain_cnt <= r_drain_cnt - 2'd1;
        if ((r_drain_cnt == 2'd1) && r_eol_q && !w_trunc) begin
          pix_eol  <= 1'b1;
          line_num <= line_num + 16'd1;
        end
      end else begin
        pix_valid <= 1'b0;
      end

      // A truncated packet never reports end-of-line, even if its pixels already drained
      if (w_trunc) r_eol_q <= 1'b0;
      if (w_hdr_done && w_dec_fs) line_num <= 16'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi_rx_depacketizer
// Description : Directed bench with a packet-level reference model for
//               csi_rx_depacketizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_rx_depacketizer;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        pix_valid, pix_sol, pix_eol, frame_start, frame_end;
  logic [13:0] pix_data;
  logic [15:0] frame_num, line_num;
  logic        err_ecc, err_dt, err_wc, err_trunc;

  csi_rx_depacketizer #(
    .VIRTUAL_CHANNEL  (2'h0),
    .EXPECTED_ECC     (8'hCC),
    .IMAGE_PIXEL_WIDTH(14)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_active  (rx_active),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .frame_num  (frame_num),
    .line_num   (line_num),
    .err_ecc    (err_ecc),
    .err_dt     (err_dt),
    .err_wc     (err_wc),
    .err_trunc  (err_trunc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output events, indexed by the clock edge after which they are visible
  bit        exp_pv    [MAXC];
  bit [13:0] exp_pd    [MAXC];
  bit        exp_sol   [MAXC];
  bit        exp_eol   [MAXC];
  bit        exp_fs    [MAXC];
  bit [15:0] exp_fsv   [MAXC];
  bit        exp_fe    [MAXC];
  bit        exp_ecc   [MAXC];
  bit        exp_dt    [MAXC];
  bit        exp_wc    [MAXC];
  bit        exp_trunc [MAXC];

  logic [15:0] m_fn = 16'd0;
  logic [15:0] m_ln = 16'd0;
  int n_checks = 0;
  int n_fail   = 0;
  int cnt_fe = 0, cnt_wc = 0, cnt_dt = 0, cnt_trunc = 0, cnt_ecc = 0;
  logic [13:0] got_pix   [$];
  logic [1:0]  got_flags [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Walks a burst packet by packet; byte i is sampled on edge t0+i, rx_active drops on edge t0+n
  function automatic void model_burst(input logic [7:0] q[$], input int t0);
    int n, pos, tc, avail, wcn, ngrp, base;
    logic [7:0] di;
    logic [15:0] wc;
    logic [7:0] g [0:6];
    bit drop, trunc;
    n = q.size();
    pos = 0;
    trunc = 1'b0;
    while (pos < n) begin
      if (n - pos < 4) begin
        trunc = 1'b1;
        break;
      end
      di  = q[pos];
      wc  = {q[pos+2], q[pos+1]};
      wcn = int'(wc);
      tc  = t0 + pos + 3;
      if (q[pos+3] != 8'hCC) begin
        exp_ecc[tc] = 1'b1;
        break;
      end
      pos   = pos + 4;
      avail = n - pos;
      drop  = 1'b0;
      if (di[7:6] != 2'h0) begin
        drop = (di[5:0] >= 6'h10);
      end else if (di[5:0] == 6'h00) begin
        exp_fs[tc]  = 1'b1;
        exp_fsv[tc] = wc;
      end else if (di[5:0] == 6'h01) begin
        exp_fe[tc] = 1'b1;
      end else if (di[5:0] == 6'h2D) begin
        if (wcn == 0 || (wcn % 7) != 0) begin
          exp_wc[tc] = 1'b1;
          drop = 1'b1;
        end else begin
          ngrp = wcn / 7;
          for (int gi = 0; gi < ngrp && 7 * (gi + 1) <= avail; gi++) begin
            for (int k = 0; k < 7; k++) g[k] = q[pos + 7 * gi + k];
            base = t0 + pos + 7 * gi + 6;
            for (int k = 0; k < 4; k++) exp_pv[base + k] = 1'b1;
            exp_pd[base]     = {g[0], g[4][5:0]};
            exp_pd[base + 1] = {g[1], g[5][3:0], g[4][7:6]};
            exp_pd[base + 2] = {g[2], g[6][1:0], g[5][7:4]};
            exp_pd[base + 3] = {g[3], g[6][7:2]};
            if (gi == 0) exp_sol[base] = 1'b1;
            if (gi == ngrp - 1 && avail >= wcn + 2) exp_eol[base + 3] = 1'b1;
          end
          if (avail < wcn + 2) begin
            trunc = 1'b1;
            break;
          end
          pos = pos + wcn + 2;
          continue;
        end
      end else begin
        exp_dt[tc] = 1'b1;
        drop = (di[5:0] >= 6'h10);
      end
      if (drop) begin
        if (avail < wcn + 2) begin
          trunc = 1'b1;
          break;
        end
        pos = pos + wcn + 2;
      end
    end
    if (trunc) exp_trunc[t0 + n] = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            64'({pix_valid, pix_data, pix_sol, pix_eol, frame_start, frame_end,
                 frame_num, line_num, err_ecc, err_dt, err_wc, err_trunc}), 64'd0);
      m_fn = 16'd0;
      m_ln = 16'd0;
    end else if (cyc < MAXC) begin
      if (exp_fs[cyc]) begin
        m_fn = exp_fsv[cyc];
        m_ln = 16'd0;
      end
      if (exp_eol[cyc]) m_ln = m_ln + 16'd1;
      check("flags",
            64'({pix_valid, pix_sol, pix_eol, frame_start, frame_end,
                 err_ecc, err_dt, err_wc, err_trunc}),
            64'({exp_pv[cyc], exp_sol[cyc], exp_eol[cyc], exp_fs[cyc], exp_fe[cyc],
                 exp_ecc[cyc], exp_dt[cyc], exp_wc[cyc], exp_trunc[cyc]}));
      if (exp_pv[cyc]) check("pix_data", 64'(pix_data), 64'(exp_pd[cyc]));
      check("counters", 64'({frame_num, line_num}), 64'({m_fn, m_ln}));
      if (pix_valid) begin
        got_pix.push_back(pix_data);
        got_flags.push_back({pix_sol, pix_eol});
      end
      if (frame_end) cnt_fe++;
      if (err_wc)    cnt_wc++;
      if (err_dt)    cnt_dt++;
      if (err_ecc)   cnt_ecc++;
      if (err_trunc) cnt_trunc++;
    end
  end

  task automatic send_burst(input logic [7:0] q[$]);
    int t0;
    t0 = cyc + 1;
    model_burst(q, t0);
    foreach (q[i]) begin
      rx_active = 1'b1;
      rx_valid  = 1'b1;
      rx_data   = q[i];
      @(negedge clk);
    end
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    rx_active = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic add_bytes(inout logic [7:0] q[$], input int n, input int seed);
    for (int i = 0; i < n; i++) q.push_back(8'((i * 37 + seed) & 255));
  endtask

  initial begin
    logic [7:0] b[$];
    int t_wc, t_tr, pix_before;
    bit saw_eol;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame start
    b = '{8'h00, 8'h05, 8'h00, 8'hCC};
    send_burst(b);
    check("fs_frame_num", 64'(frame_num), 64'(16'h0005));
    check("fs_line_num", 64'(line_num), 64'(16'h0000));

    // RAW14 line, 28 bytes
    got_pix.delete();
    got_flags.delete();
    b = '{8'h2D, 8'h1C, 8'h00, 8'hCC, 8'h12, 8'h34, 8'h56, 8'h78, 8'h3F, 8'h00, 8'h00};
    add_bytes(b, 21, 11);
    b.push_back(8'hA5);
    b.push_back(8'h5A);
    send_burst(b);
    check("raw_pix_count", 64'(got_pix.size()), 64'd16);
    if (got_pix.size() == 16) begin
      check("raw_pix0", 64'(got_pix[0]), 64'(14'h04BF));
      check("raw_pix1", 64'(got_pix[1]), 64'(14'h0D00));
      check("raw_pix2", 64'(got_pix[2]), 64'(14'h1580));
      check("raw_pix3", 64'(got_pix[3]), 64'(14'h1E00));
      check("raw_sol_first", 64'(got_flags[0]), 64'(2'b10));
      check("raw_eol_last", 64'(got_flags[15]), 64'(2'b01));
    end
    check("raw_line_num", 64'(line_num), 64'(16'h0001));

    // Bad ECC: embedded FS must be ignored until the burst ends
    got_pix.delete();
    b = '{8'h2D, 8'h1C, 8'h00, 8'hCD, 8'h00, 8'h07, 8'h00, 8'hCC};
    add_bytes(b, 10, 3);
    send_burst(b);
    check("ecc_count", 64'(cnt_ecc), 64'd1);
    check("ecc_no_pixels", 64'(got_pix.size()), 64'd0);
    check("ecc_frame_num", 64'(frame_num), 64'(16'h0005));

    // Bad WC drop, frame end, short unknown DT, other-VC drop, frame start
    b = '{8'h2D, 8'h1B, 8'h00, 8'hCC};
    add_bytes(b, 29, 5);
    b = {b, 8'h01, 8'h00, 8'h00, 8'hCC, 8'h05, 8'h00, 8'h00, 8'hCC, 8'h6D, 8'h07, 8'h00, 8'hCC};
    add_bytes(b, 9, 7);
    b = {b, 8'h00, 8'h09, 8'h00, 8'hCC};
    send_burst(b);
    check("wc_err_count", 64'(cnt_wc), 64'd1);
    check("fe_count", 64'(cnt_fe), 64'd1);
    check("dt_err_count", 64'(cnt_dt), 64'd1);
    check("vc_frame_num", 64'(frame_num), 64'(16'h0009));

    // Two lines in one burst: WC=7 then WC=14
    got_pix.delete();
    b = '{8'h2D, 8'h07, 8'h00, 8'hCC};
    add_bytes(b, 9, 19);
    b = {b, 8'h2D, 8'h0E, 8'h00, 8'hCC};
    add_bytes(b, 16, 23);
    send_burst(b);
    check("two_line_pixels", 64'(got_pix.size()), 64'd12);
    check("two_line_num", 64'(line_num), 64'(16'h0002));

    // Truncation mid-payload, then in a partial header
    got_pix.delete();
    got_flags.delete();
    t_tr = cnt_trunc;
    b = '{8'h2D, 8'h1C, 8'h00, 8'hCC};
    add_bytes(b, 10, 29);
    send_burst(b);
    saw_eol = 1'b0;
    foreach (got_flags[i]) if (got_flags[i][0]) saw_eol = 1'b1;
    check("trunc_pixels", 64'(got_pix.size()), 64'd4);
    check("trunc_no_eol", 64'(saw_eol), 64'd0);
    check("trunc_count", 64'(cnt_trunc - t_tr), 64'd1);
    check("trunc_line_num", 64'(line_num), 64'(16'h0002));
    b = '{8'h00, 8'h05};
    send_burst(b);
    check("hdr_trunc_count", 64'(cnt_trunc - t_tr), 64'd2);
    t_wc = cnt_wc;

    // Reset asserted right after payload byte 5
    b = '{8'h2D, 8'h1C, 8'h00, 8'hCC};
    add_bytes(b, 5, 31);
    foreach (b[i]) begin
      rx_active = 1'b1;
      rx_valid  = 1'b1;
      rx_data   = b[i];
      if (i < b.size() - 1) @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_active = 1'b0;
    rx_data   = 8'd0;
    #1 check("rst_async_frame_num", 64'(frame_num), 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pix_before = got_pix.size();

    b = '{8'h00, 8'h2A, 8'h00, 8'hCC};
    send_burst(b);
    check("post_rst_frame_num", 64'(frame_num), 64'(16'h002A));
    check("post_rst_no_pixels", 64'(got_pix.size() - pix_before), 64'd0);
    check("post_rst_no_wc_err", 64'(cnt_wc - t_wc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csi_rx_depacketizer.md
CSI_RX_DEPACKETIZER -- requirements
Module: csi_rx_depacketizer

Interface
REQ-001 SHALL have parameter VIRTUAL_CHANNEL, default 2'h0: packets with any other VC are dropped.
REQ-002 SHALL have parameter EXPECTED_ECC, default 8'hCC: required value of header byte 3.
REQ-003 SHALL have parameter IMAGE_PIXEL_WIDTH, default 14: output pixel width; only 14 is supported.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rx_active, input, 1 bit: high for the duration of an HS burst.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte this cycle; no backpressure exists.
REQ-008 SHALL have port rx_data, input, 8 bits: received byte, in packet order.
REQ-009 SHALL have outputs pix_valid (1), pix_data (14), pix_sol (1), pix_eol (1): pixel stream plus start-of-line and end-of-line flags.
REQ-010 SHALL have outputs frame_start (1) and frame_end (1): single-cycle pulses.
REQ-011 SHALL have outputs frame_num (16) and line_num (16): counters.
REQ-012 SHALL have outputs err_ecc, err_dt, err_wc, err_trunc (1 bit each): single-cycle error pulses.

Function
REQ-013 SHALL implement states IDLE, HDR, PAYLOAD, FOOTER, DROP, DROP_BURST.
REQ-014 SHALL move IDLE->HDR on any rx_valid byte while rx_active=1; that byte is header byte 0.
REQ-015 SHALL decode the header as: byte0 = DI (VC=[7:6], DT=[5:0]), byte1 = WC LSB, byte2 = WC MSB, byte3 = ECC.
REQ-016 SHALL, on a byte3 value != EXPECTED_ECC, pulse err_ecc and go to DROP_BURST.
REQ-017 SHALL, in DROP_BURST, ignore all bytes until rx_active=0, then go to IDLE.
REQ-018 SHALL, on a VC mismatch with correct ECC: drop WC+2 bytes for DT>=0x10, or return to HDR for DT<0x10; no error is flagged.
REQ-019 SHALL, on DT=0x00 (frame start): pulse frame_start the cycle after byte3, load frame_num<=WC field, clear line_num to 0, and return to HDR.
REQ-020 SHALL, on DT=0x01 (frame end): pulse frame_end the cycle after byte3 and return to HDR.
REQ-021 SHALL, on DT=0x2D (RAW14): check WC; if WC=0 or WC mod 7 != 0, pulse err_wc and go to DROP for WC+2 bytes; otherwise go to PAYLOAD.
REQ-022 SHALL, on any other DT: pulse err_dt; go to DROP for WC+2 bytes if DT>=0x10, else return to HDR.
REQ-023 SHALL, in PAYLOAD, consume exactly WC bytes in groups of 7.
REQ-024 SHALL unpack each group as: P1={b0,b4[5:0]}, P2={b1,b5[3:0],b4[7:6]}, P3={b2,b6[1:0],b5[7:4]}, P4={b3,b6[7:2]}.
REQ-025 SHALL output P1..P4 with pix_valid=1 on the 4 consecutive cycles following acceptance of group byte 6; a new group cannot complete within 4 cycles, so no overlap occurs.
REQ-026 SHALL assert pix_sol with the first pixel of the packet.
REQ-027 SHALL assert pix_eol with pixel number (WC/7)*4 of the packet, and increment line_num in the same cycle.
REQ-028 SHALL, after WC bytes, consume 2 footer bytes in FOOTER; the checksum is not checked.
REQ-029 SHALL return to HDR after the footer, allowing multiple packets per burst.
REQ-030 SHALL, in DROP, count the remaining bytes and then return to HDR.
REQ-031 SHALL, in HDR with 0 bytes collected, go to IDLE without error when rx_active falls.
REQ-032 SHALL, when rx_active falls in HDR (1-3 bytes), PAYLOAD, FOOTER or DROP, pulse err_trunc and go to IDLE.
REQ-033 SHALL, on truncation, discard the partial group; already-completed groups still drain, and no pix_eol is issued.
REQ-034 SHALL, when rx_active falls in the same cycle as a final byte, treat that byte as accepted.
REQ-035 SHALL wrap frame_num and line_num modulo 2^16.
REQ-036 SHALL hold pix_data, frame_num and line_num stable when not being updated.

Reset
REQ-037 SHALL, on rst_n=0 at any time (including mid-packet or mid-drain), immediately enter IDLE, drive every output to 0, and clear all counters and byte buffers.
REQ-038 SHALL, after reset release, ignore bytes until the next byte accepted in IDLE per REQ-014.

Verification
REQ-039 SHALL cover: burst 00 05 00 CC -> frame_start pulse 1 cycle after CC, frame_num=0x0005, line_num=0.
REQ-040 SHALL cover: burst 2D 1C 00 CC, then 28 payload bytes starting 12 34 56 78 3F 00 00, then 2 footer bytes -> first pixels 0x04BF, 0x0D00, 0x1580, 0x1E00; 16 pixels total; pix_sol on pixel 1; pix_eol on pixel 16; line_num=1.
REQ-041 SHALL cover: header 2D 1C 00 CD -> err_ecc pulse, no pixels, all further bytes ignored until rx_active=0.
REQ-042 SHALL cover: header 2D 1B 00 CC -> err_wc pulse, 29 bytes dropped, and a following 01 00 00 CC in the same burst -> frame_end pulse.
REQ-043 SHALL cover: valid RAW14 header followed by 10 payload bytes, then rx_active=0 -> 4 pixels out, err_trunc pulse, no pix_eol, state IDLE.
REQ-044 SHALL cover: rst_n asserted at payload byte 5 -> all outputs 0 that cycle; after release, a clean FS packet is decoded correctly.
